// File: rtl/csr_file_if.sv
// ---------------------------------------------------------------------------
// csr_file_if : controller <-> machine-mode CSR file signal bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface csr_file_if;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wd;
  logic [31:0] csr_rd;
  logic        csr_illegal;
  logic        instret;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic        mret;
  logic [31:0] mtvec_out;
  logic [31:0] mepc_out;
  logic        mie_out;

  modport master (
    output csr_addr, csr_we, csr_wd, instret, trap_valid, trap_cause, trap_pc, mret,
    input  csr_rd, csr_illegal, mtvec_out, mepc_out, mie_out
  );

  modport slave (
    input  csr_addr, csr_we, csr_wd, instret, trap_valid, trap_cause, trap_pc, mret,
    output csr_rd, csr_illegal, mtvec_out, mepc_out, mie_out
  );
endinterface

`default_nettype wire

// File: rtl/csr_file.sv
// ---------------------------------------------------------------------------
// csr_file : RV32I machine-mode CSRs, trap/mret state and 64-bit counters
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module csr_file #(
  parameter logic [31:0] HART_ID = 32'd0,
  parameter logic [31:0] MISA    = 32'h4000_0100
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  csr_file_if.slave   bus
);

  localparam logic [11:0] c_MSTATUS   = 12'h300;
  localparam logic [11:0] c_MISA      = 12'h301;
  localparam logic [11:0] c_MTVEC     = 12'h305;
  localparam logic [11:0] c_MSCRATCH  = 12'h340;
  localparam logic [11:0] c_MEPC      = 12'h341;
  localparam logic [11:0] c_MCAUSE    = 12'h342;
  localparam logic [11:0] c_MHARTID   = 12'hF14;
  localparam logic [11:0] c_MCYCLE    = 12'hB00;
  localparam logic [11:0] c_MCYCLEH   = 12'hB80;
  localparam logic [11:0] c_MINSTRET  = 12'hB02;
  localparam logic [11:0] c_MINSTRETH = 12'hB82;
  localparam logic [11:0] c_CYCLE     = 12'hC00;
  localparam logic [11:0] c_CYCLEH    = 12'hC80;
  localparam logic [11:0] c_INSTRET   = 12'hC02;
  localparam logic [11:0] c_INSTRETH  = 12'hC82;
  localparam logic [31:0] c_ALIGN4    = 32'hFFFF_FFFC;

  logic        r_mie;
  logic        r_mpie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [63:0] r_mcycle;
  logic [63:0] r_minstret;

  logic [31:0] w_rd;
  logic        w_illegal;
  logic        w_ro;
  logic        w_wr;
  logic        w_wr_mstatus;

  always_comb begin
    w_rd      = 32'd0;
    w_illegal = 1'b0;
    case (bus.csr_addr)
      c_MSTATUS:              w_rd = {24'd0, r_mpie, 3'd0, r_mie, 3'd0};
      c_MISA:                 w_rd = MISA;
      c_MHARTID:              w_rd = HART_ID;
      c_MTVEC:                w_rd = r_mtvec;
      c_MSCRATCH:             w_rd = r_mscratch;
      c_MEPC:                 w_rd = r_mepc;
      c_MCAUSE:               w_rd = r_mcause;
      c_MCYCLE,   c_CYCLE:    w_rd = r_mcycle[31:0];
      c_MCYCLEH,  c_CYCLEH:   w_rd = r_mcycle[63:32];
      c_MINSTRET, c_INSTRET:  w_rd = r_minstret[31:0];
      c_MINSTRETH,c_INSTRETH: w_rd = r_minstret[63:32];
      default:                w_illegal = 1'b1;
    endcase
  end

  // A trap swallows every CSR write of its cycle; mret only blocks mstatus.
  assign w_ro = (bus.csr_addr[11:10] == 2'b11) || (bus.csr_addr == c_MISA) ||
                (bus.csr_addr == c_MHARTID);
  assign w_wr = bus.csr_we && !bus.trap_valid && !w_illegal && !w_ro;
  assign w_wr_mstatus = w_wr && !bus.mret && (bus.csr_addr == c_MSTATUS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mie  <= 1'b0;
      r_mpie <= 1'b0;
    end else if (bus.trap_valid) begin
      r_mpie <= r_mie;
      r_mie  <= 1'b0;
    end else if (bus.mret) begin
      r_mie  <= r_mpie;
      r_mpie <= 1'b1;
    end else if (w_wr_mstatus) begin
      r_mie  <= bus.csr_wd[3];
      r_mpie <= bus.csr_wd[7];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtvec    <= 32'd0;
      r_mscratch <= 32'd0;
      r_mepc     <= 32'd0;
      r_mcause   <= 32'd0;
    end else if (bus.trap_valid) begin
      r_mepc     <= bus.trap_pc & c_ALIGN4;
      r_mcause   <= bus.trap_cause;
    end else if (w_wr) begin
      case (bus.csr_addr)
        c_MTVEC:    r_mtvec    <= bus.csr_wd & c_ALIGN4;
        c_MSCRATCH: r_mscratch <= bus.csr_wd;
        c_MEPC:     r_mepc     <= bus.csr_wd & c_ALIGN4;
        c_MCAUSE:   r_mcause   <= bus.csr_wd;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcycle <= 64'd0;
    end else if (w_wr && (bus.csr_addr == c_MCYCLE)) begin
      r_mcycle <= {r_mcycle[63:32], bus.csr_wd};
    end else if (w_wr && (bus.csr_addr == c_MCYCLEH)) begin
      r_mcycle <= {bus.csr_wd, r_mcycle[31:0]};
    end else begin
      r_mcycle <= r_mcycle + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_minstret <= 64'd0;
    end else if (w_wr && (bus.csr_addr == c_MINSTRET)) begin
      r_minstret <= {r_minstret[63:32], bus.csr_wd};
    end else if (w_wr && (bus.csr_addr == c_MINSTRETH)) begin
      r_minstret <= {bus.csr_wd, r_minstret[31:0]};
    end else if (bus.instret) begin
      r_minstret <= r_minstret + 64'd1;
    end
  end

  assign bus.csr_rd      = w_rd;
  assign bus.csr_illegal = w_illegal;
  assign bus.mtvec_out   = r_mtvec;
  assign bus.mepc_out    = r_mepc;
  assign bus.mie_out     = r_mie;

endmodule

`default_nettype wire
